cyclic_seq: RTL and testbench
=============================

Name: cyclic_seq

Overview:
Parametrised cyclic state sequencer; the next generation of the team's fixed 3-state ring FSM.
- Steps through NSTATES states, modulo NSTATES, with enable, up/down direction and synchronous load.
- Flags wrap-around and rejects illegal loads.
- Presents the state as binary or Gray code.
- Used as a phase/slot generator for downstream control logic.

Parameters:
NSTATES, 3, number of states in the cycle (legal range >= 2)
RESET_STATE, 0, state entered on reset (must be < NSTATES)
GRAY_OUT, 0, 0 = y is binary state; 1 = y is Gray-coded state
W (localparam), max(1, $clog2(NSTATES)), width of the state and y ports

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset, asynchronous, active-high
en  in  1  advance the state by one step this cycle
dir  in  1  0 = count up (S(k) -> S(k+1)); 1 = count down
load  in  1  synchronous load of load_val; has priority over en
load_val  in  W  state index to load
state  out  W  current state index, binary, registered
y  out  W  encoded state: binary or Gray per GRAY_OUT; combinational from state
wrap  out  1  one-cycle registered pulse after a wrap transition
load_err  out  1  one-cycle registered pulse after a rejected load

Behaviour:
- Clock and reset: one clock `clk`; reset `rst` is asynchronous and active-high.
- Reset:
  - While `rst` is high, state = RESET_STATE and wrap = 0, load_err = 0, without waiting for a clock edge.
  - y equals the encoding of RESET_STATE.
  - Reset mid-sequence abandons the current position immediately.
  - The first edge after `rst` deasserts behaves normally.
- Priority at each rising edge (rst low):
  1. `load` = 1 and load_val < NSTATES: state <= load_val; wrap <= 0; load_err <= 0. `en`/`dir` ignored.
  2. `load` = 1 and load_val >= NSTATES: state unchanged; load_err <= 1; wrap <= 0. `en` ignored.
  3. `load` = 0, `en` = 1, `dir` = 0:
     - state <= (state == NSTATES-1) ? 0 : state+1.
     - wrap <= 1 exactly when state was NSTATES-1.
  4. `load` = 0, `en` = 1, `dir` = 1:
     - state <= (state == 0) ? NSTATES-1 : state-1.
     - wrap <= 1 exactly when state was 0.
  5. Otherwise: state holds; wrap <= 0; load_err <= 0.
- Latency and pulses:
  - One cycle from `en`/`load` sampling to the new state.
  - wrap and load_err are high for exactly one cycle, aligned with the new state value.
  - Consecutive wraps give consecutive pulses. This includes NSTATES=2 and a reversed `dir` on the next cycle.
- Wrap rules:
  - A load never produces wrap, even if it loads 0 or NSTATES-1.
  - A direction change without a boundary crossing produces no wrap.
- Encoding:
  - Gray: y = state ^ (state >> 1).
  - For non-power-of-two NSTATES the wrap step in Gray mode is not single-bit. This is accepted and is not corrected.
- Illegal state: state values >= NSTATES are unreachable. If one occurs (e.g. SEU), the next edge with `en` = 1 moves to RESET_STATE. wrap stays 0.
- Elaboration: fatal error if NSTATES < 2 or RESET_STATE >= NSTATES.
- No latches. `state` is the only multi-bit register. wrap and load_err are flops.

Decomposition:
- Shared package `seq_pkg`:
  - typedef enum {ENC_BIN, ENC_GRAY} for GRAY_OUT decoding.
  - Function `bin2gray(logic [W-1:0])`.
  - Helper function `clog2_min1`.
- One natural sub-module: `gray_enc`, a purely combinational W-bit binary-to-Gray encoder instantiated under GRAY_OUT=1. Also reusable elsewhere.
- Next-state logic lives in cyclic_seq itself, in a single combinational process plus one clocked process.

Test Plan:
1. NSTATES=3, GRAY_OUT=0, rst pulse, then en=1, dir=0 for 7 cycles -> state 0,1,2,0,1,2,0,1; wrap high in the cycles where state shows 0 after 2 (2 pulses).
2. NSTATES=5, en=1, dir=1 from state 0 -> state 4,3,2,1,0,4; wrap high with the first 4 and the final 4 only.
3. NSTATES=5, load=1, load_val=3 with en=1 -> state=3, no wrap; then load_val=6 -> state stays 3, load_err=1 for one cycle; then load_val=7 -> load_err=1 again.
4. NSTATES=8, GRAY_OUT=1, count up from 0 -> y = 0,1,3,2,6,7,5,4,0; every step, including the wrap, changes exactly one bit.
5. NSTATES=4, RESET_STATE=2: advance to 3, assert rst asynchronously mid-cycle -> state=2 and wrap=0 before the next edge; release -> counting resumes 3,0 (wrap),1.
6. NSTATES=2, en=1, toggle dir each cycle from 0 -> state 1,0,1,0 with wrap asserted on every step.

Source files
------------

// File: rtl/cyclic_seq_pkg.sv
// Shared definitions for the cyclic state sequencer family: output encoding
// selector, width helper and a generic binary-to-Gray conversion.
package seq_pkg;

    typedef enum logic {
        ENC_BIN  = 1'b0,
        ENC_GRAY = 1'b1
    } enc_t;

    // Widest vector the generic helpers below operate on.
    localparam int MAX_W = 32;

    // Bits needed to hold indices 0..n-1, never less than one bit.
    function automatic int clog2_min1(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    // Generic binary-to-Gray conversion; callers zero-extend narrower values.
    function automatic logic [MAX_W-1:0] bin2gray(input logic [MAX_W-1:0] b);
        return b ^ (b >> 1);
    endfunction

endpackage

// File: rtl/cyclic_seq_gray_enc.sv
// Purely combinational W-bit binary-to-Gray encoder.
module gray_enc #(
    parameter int W = 2
) (
    input  logic [W-1:0] bin,
    output logic [W-1:0] gray
);

    // Each Gray bit is the XOR of a binary bit with its more-significant neighbour.
    for (genvar gi = 0; gi < W - 1; gi++) begin : g_bit
        assign gray[gi] = bin[gi] ^ bin[gi+1];
    end

    // The MSB passes through unchanged.
    assign gray[W-1] = bin[W-1];

endmodule

// File: rtl/cyclic_seq.sv
// Parametrised cyclic state sequencer: steps through NSTATES states with
// enable, up/down direction and a checked synchronous load. Flags wrap-around
// and rejected loads, and presents the state in binary or Gray code.
module cyclic_seq
    import seq_pkg::*;
#(
    parameter  int NSTATES     = 3,
    parameter  int RESET_STATE = 0,
    parameter  int GRAY_OUT    = 0,
    localparam int W           = clog2_min1(NSTATES)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic         dir,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic [W-1:0] state,
    output logic [W-1:0] y,
    output logic         wrap,
    output logic         load_err
);

    localparam logic [W:0]   N_EXT   = (W+1)'(NSTATES);
    localparam logic [W-1:0] LAST    = W'(NSTATES - 1);
    localparam logic [W-1:0] RST_VAL = W'(RESET_STATE);
    localparam enc_t         ENC     = (GRAY_OUT != 0) ? ENC_GRAY : ENC_BIN;

    // Reject parameter sets that cannot describe a valid cycle.
    if (NSTATES < 2) begin : g_bad_nstates
        $fatal(1, "cyclic_seq: NSTATES must be >= 2");
    end
    if (RESET_STATE >= NSTATES || RESET_STATE < 0) begin : g_bad_reset_state
        $fatal(1, "cyclic_seq: RESET_STATE must be in 0..NSTATES-1");
    end

    logic [W-1:0] state_reg;
    logic [W-1:0] state_next;
    logic         wrap_reg;
    logic         wrap_next;
    logic         load_err_reg;
    logic         load_err_next;
    logic         state_ok;
    logic         load_ok;

    // Range checks are done one bit wider so NSTATES == 2**W compares cleanly.
    assign state_ok = ({1'b0, state_reg} < N_EXT);
    assign load_ok  = ({1'b0, load_val} < N_EXT);

    // Next-state and pulse selection: load beats en; an out-of-range state
    // (only reachable by an upset) recovers to RESET_STATE on the next step.
    always_comb begin
        state_next    = state_reg;
        wrap_next     = 1'b0;
        load_err_next = 1'b0;
        if (load) begin
            if (load_ok) begin
                state_next = load_val;
            end else begin
                load_err_next = 1'b1;
            end
        end else if (en) begin
            if (!state_ok) begin
                state_next = RST_VAL;
            end else if (!dir) begin
                if (state_reg == LAST) begin
                    state_next = '0;
                    wrap_next  = 1'b1;
                end else begin
                    state_next = state_reg + 1'b1;
                end
            end else begin
                if (state_reg == '0) begin
                    state_next = LAST;
                    wrap_next  = 1'b1;
                end else begin
                    state_next = state_reg - 1'b1;
                end
            end
        end
    end

    // State and pulse registers; reset acts immediately, without a clock edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg    <= RST_VAL;
            wrap_reg     <= 1'b0;
            load_err_reg <= 1'b0;
        end else begin
            state_reg    <= state_next;
            wrap_reg     <= wrap_next;
            load_err_reg <= load_err_next;
        end
    end

    assign state    = state_reg;
    assign wrap     = wrap_reg;
    assign load_err = load_err_reg;

    // Output encoding is chosen at elaboration time.
    if (ENC == ENC_GRAY) begin : g_gray
        gray_enc #(.W(W)) u_gray (
            .bin  (state_reg),
            .gray (y)
        );
    end else begin : g_bin
        assign y = state_reg;
    end

endmodule

// File: tb/tb_cyclic_seq.sv
// Self-checking bench for cyclic_seq: five parameter variants share one
// stimulus stream; directed table rows, an asynchronous-reset sequence and a
// randomized run compared against an arithmetic reference model.
module tb_cyclic_seq;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       en = 1'b0;
    logic       dir = 1'b0;
    logic       load = 1'b0;
    logic [2:0] lv = 3'd0;

    always #5 clk = ~clk;

    logic [1:0] s0, y0;
    logic [2:0] s1, y1;
    logic [2:0] s2, y2;
    logic [1:0] s3, y3;
    logic [0:0] s4, y4;
    logic [4:0] wr;
    logic [4:0] le;

    cyclic_seq #(.NSTATES(3), .RESET_STATE(0), .GRAY_OUT(0)) u0 (
        .clk(clk), .rst(rst), .en(en), .dir(dir), .load(load), .load_val(lv[1:0]),
        .state(s0), .y(y0), .wrap(wr[0]), .load_err(le[0]));
    cyclic_seq #(.NSTATES(5), .RESET_STATE(0), .GRAY_OUT(0)) u1 (
        .clk(clk), .rst(rst), .en(en), .dir(dir), .load(load), .load_val(lv[2:0]),
        .state(s1), .y(y1), .wrap(wr[1]), .load_err(le[1]));
    cyclic_seq #(.NSTATES(8), .RESET_STATE(0), .GRAY_OUT(1)) u2 (
        .clk(clk), .rst(rst), .en(en), .dir(dir), .load(load), .load_val(lv[2:0]),
        .state(s2), .y(y2), .wrap(wr[2]), .load_err(le[2]));
    cyclic_seq #(.NSTATES(4), .RESET_STATE(2), .GRAY_OUT(0)) u3 (
        .clk(clk), .rst(rst), .en(en), .dir(dir), .load(load), .load_val(lv[1:0]),
        .state(s3), .y(y3), .wrap(wr[3]), .load_err(le[3]));
    cyclic_seq #(.NSTATES(2), .RESET_STATE(0), .GRAY_OUT(0)) u4 (
        .clk(clk), .rst(rst), .en(en), .dir(dir), .load(load), .load_val(lv[0:0]),
        .state(s4), .y(y4), .wrap(wr[4]), .load_err(le[4]));

    logic [31:0] st_a [5];
    logic [31:0] y_a  [5];
    always_comb begin
        st_a[0] = 32'(s0); y_a[0] = 32'(y0);
        st_a[1] = 32'(s1); y_a[1] = 32'(y1);
        st_a[2] = 32'(s2); y_a[2] = 32'(y2);
        st_a[3] = 32'(s3); y_a[3] = 32'(y3);
        st_a[4] = 32'(s4); y_a[4] = 32'(y4);
    end

    // Per-instance configuration, used only by the reference model.
    int ns [5] = '{3, 5, 8, 4, 2};
    int rs [5] = '{0, 0, 0, 2, 0};
    int gr [5] = '{0, 0, 1, 0, 0};
    int wd [5] = '{2, 3, 3, 2, 1};

    int n_checks = 0;
    int n_fail   = 0;

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic check_inst(input int k, input int es, input int ey, input int ew,
                              input int ee, input string tag);
        cmp($sformatf("%s.u%0d.state", tag, k), st_a[k], es);
        cmp($sformatf("%s.u%0d.y", tag, k), y_a[k], ey);
        cmp($sformatf("%s.u%0d.wrap", tag, k), 32'(wr[k]), ew);
        cmp($sformatf("%s.u%0d.load_err", tag, k), 32'(le[k]), ee);
    endtask

    typedef struct {
        bit       rst;
        bit       en;
        bit       dir;
        bit       load;
        bit [2:0] lv;
        int       k;
        int       es;
        int       ey;
        int       ew;
        int       ee;
    } vec_t;

    vec_t tv[$];

    function automatic void add(input bit r, input bit e, input bit d, input bit l,
                                input int v, input int k, input int es, input int ey,
                                input int ew, input int ee);
        vec_t t;
        t.rst = r; t.en = e; t.dir = d; t.load = l; t.lv = 3'(v);
        t.k = k; t.es = es; t.ey = ey; t.ew = ew; t.ee = ee;
        tv.push_back(t);
    endfunction

    // Reference model: modular arithmetic on plain integers.
    int m_st [5];
    int m_w  [5];
    int m_e  [5];

    function automatic void model_step(input int k);
        int n;
        int lvm;
        n   = ns[k];
        lvm = int'(lv) % (1 << wd[k]);
        m_w[k] = 0;
        m_e[k] = 0;
        if (rst) begin
            m_st[k] = rs[k];
        end else if (load) begin
            if (lvm < n) m_st[k] = lvm;
            else         m_e[k]  = 1;
        end else if (en) begin
            if (!dir) begin
                m_w[k]  = (m_st[k] == n - 1) ? 1 : 0;
                m_st[k] = (m_st[k] + 1) % n;
            end else begin
                m_w[k]  = (m_st[k] == 0) ? 1 : 0;
                m_st[k] = (m_st[k] + n - 1) % n;
            end
        end
    endfunction

    function automatic int enc(input int k, input int s);
        return (gr[k] != 0) ? (s ^ (s >> 1)) : s;
    endfunction

    initial begin
        int prev_y2;
        int gray_y [8];
        gray_y = '{1, 3, 2, 6, 7, 5, 4, 0};

        // Count up, NSTATES=3: wrap each time 2 rolls over to 0.
        add(1,0,0,0,0, 0, 0,0,0,0);
        add(0,1,0,0,0, 0, 1,1,0,0);
        add(0,1,0,0,0, 0, 2,2,0,0);
        add(0,1,0,0,0, 0, 0,0,1,0);
        add(0,1,0,0,0, 0, 1,1,0,0);
        add(0,1,0,0,0, 0, 2,2,0,0);
        add(0,1,0,0,0, 0, 0,0,1,0);
        add(0,1,0,0,0, 0, 1,1,0,0);
        // Loads of the boundary values never wrap; illegal load holds state.
        add(0,1,0,1,2, 0, 2,2,0,0);
        add(0,1,0,1,0, 0, 0,0,0,0);
        add(0,1,1,1,3, 0, 0,0,0,1);
        // Direction change away from a boundary: no wrap.
        add(0,1,0,0,0, 0, 1,1,0,0);
        add(0,1,1,0,0, 0, 0,0,0,0);
        add(0,1,1,0,0, 0, 2,2,1,0);
        // Count down, NSTATES=5.
        add(1,0,0,0,0, 1, 0,0,0,0);
        add(0,1,1,0,0, 1, 4,4,1,0);
        add(0,1,1,0,0, 1, 3,3,0,0);
        add(0,1,1,0,0, 1, 2,2,0,0);
        add(0,1,1,0,0, 1, 1,1,0,0);
        add(0,1,1,0,0, 1, 0,0,0,0);
        add(0,1,1,0,0, 1, 4,4,1,0);
        // Legal and illegal loads, NSTATES=5.
        add(0,1,0,1,3, 1, 3,3,0,0);
        add(0,1,0,1,6, 1, 3,3,0,1);
        add(0,1,0,1,7, 1, 3,3,0,1);
        add(0,0,0,0,0, 1, 3,3,0,0);
        // Gray output, NSTATES=8.
        add(1,0,0,0,0, 2, 0,0,0,0);
        for (int i = 0; i < 8; i++) add(0,1,0,0,0, 2, (i + 1) % 8, gray_y[i], (i == 7) ? 1 : 0, 0);
        // NSTATES=2 with dir reversed every cycle: every step crosses a boundary.
        add(1,0,0,0,0, 4, 0,0,0,0);
        add(0,1,1,0,0, 4, 1,1,1,0);
        add(0,1,0,0,0, 4, 0,0,1,0);
        add(0,1,1,0,0, 4, 1,1,1,0);
        add(0,1,0,0,0, 4, 0,0,1,0);

        @(posedge clk); #1;
        for (int i = 0; i < tv.size(); i++) begin
            rst = tv[i].rst; en = tv[i].en; dir = tv[i].dir;
            load = tv[i].load; lv = tv[i].lv;
            @(posedge clk); #1;
            $display("vec %0d: u%0d rst=%0b en=%0b dir=%0b load=%0b lv=%0d -> state=%0d wrap=%0b err=%0b",
                     i, tv[i].k, rst, en, dir, load, lv, st_a[tv[i].k], wr[tv[i].k], le[tv[i].k]);
            check_inst(tv[i].k, tv[i].es, tv[i].ey, tv[i].ew, tv[i].ee, $sformatf("vec%0d", i));
        end

        // Asynchronous reset mid-cycle, NSTATES=4, RESET_STATE=2.
        rst = 1; en = 0; load = 0; dir = 0;
        @(posedge clk); #1;
        rst = 0;
        check_inst(3, 2, 2, 0, 0, "arst.init");
        en = 1;
        @(posedge clk); #1;
        check_inst(3, 3, 3, 0, 0, "arst.step3");
        @(posedge clk); #1;
        check_inst(3, 0, 0, 1, 0, "arst.wrap0");
        #2 rst = 1;
        #1;
        $display("arst: rst asserted mid-cycle -> state=%0d wrap=%0b", s3, wr[3]);
        check_inst(3, 2, 2, 0, 0, "arst.async");
        #1 rst = 0;
        @(posedge clk); #1;
        check_inst(3, 3, 3, 0, 0, "arst.resume3");
        @(posedge clk); #1;
        check_inst(3, 0, 0, 1, 0, "arst.resume0");
        @(posedge clk); #1;
        check_inst(3, 1, 1, 0, 0, "arst.resume1");

        // Randomized run against the reference model, all five variants.
        prev_y2 = 0;
        for (int c = 0; c < 400; c++) begin
            rst  = (c == 0) || ($urandom_range(0, 49) == 0);
            en   = $urandom_range(0, 3) != 0;
            dir  = 1'($urandom_range(0, 1));
            load = $urandom_range(0, 4) == 0;
            lv   = 3'($urandom_range(0, 7));
            for (int k = 0; k < 5; k++) model_step(k);
            prev_y2 = int'(y2);
            @(posedge clk); #1;
            $display("rnd %0d: rst=%0b en=%0b dir=%0b load=%0b lv=%0d -> s=%0d,%0d,%0d,%0d,%0d",
                     c, rst, en, dir, load, lv, s0, s1, s2, s3, s4);
            for (int k = 0; k < 5; k++)
                check_inst(k, m_st[k], enc(k, m_st[k]), m_w[k], m_e[k], $sformatf("rnd%0d", c));
            if (!rst && !load && en)
                cmp($sformatf("rnd%0d.gray_1bit", c), 32'($countones(3'(prev_y2) ^ y2)), 1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
